// File: rtl/fifo_bank_scheduler.sv
// rtl/fifo_bank_scheduler.sv - round-robin req/ack scheduler over a shared pool of four FIFO banks
// Tracks per-bank occupancy, rotates the write bank over non-full banks, and drains every bank on flush.
module fifo_bank_scheduler #(
  parameter int NUM_M  = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_req,
  input  logic [NUM_M-1:0]          m_we,
  input  logic [2*NUM_M-1:0]        m_rd_id,
  input  logic [DATA_W*NUM_M-1:0]   m_wdata,
  output logic [NUM_M-1:0]          m_ack,
  output logic [NUM_M-1:0]          m_err,
  output logic [NUM_M-1:0]          m_rvalid,
  output logic [DATA_W-1:0]         m_rdata,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [3:0]                b_wr_en,
  output logic [3:0]                b_rd_en,
  output logic [DATA_W-1:0]         b_wdata,
  input  logic [4*DATA_W-1:0]       b_rdata,
  output logic [4*CNT_W-1:0]        bank_cnt
);

  localparam int AW = (NUM_M > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      arb_ptr, arb_ptr_nxt;
  logic [1:0]         wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]   cnt [4];
  logic [CNT_W-1:0]   cnt_nxt [4];
  logic [NUM_M-1:0]   rvalid_q, rvalid_nxt;
  logic [1:0]         rd_bank_q, rd_bank_nxt;
  logic [DATA_W-1:0]  rdata_hold;

  logic [NUM_M-1:0]   ack_c, err_c;
  logic [3:0]         wr_c, rd_c;
  logic [DATA_W-1:0]  wdata_c;
  logic               done_c;
  logic               win_found, wb_found;
  logic [AW-1:0]      win;
  logic [1:0]         wb, rb;
  int                 idx;

  always_comb begin
    state_nxt   = state;
    arb_ptr_nxt = arb_ptr;
    wr_ptr_nxt  = wr_ptr;
    cnt_nxt     = cnt;
    rvalid_nxt  = '0;
    rd_bank_nxt = rd_bank_q;
    ack_c       = '0;
    err_c       = '0;
    wr_c        = '0;
    rd_c        = '0;
    wdata_c     = '0;
    done_c      = 1'b0;
    win_found   = 1'b0;
    win         = '0;
    wb_found    = 1'b0;
    wb          = '0;
    rb          = '0;
    idx         = 0;

    for (int o = 0; o < NUM_M; o++) begin
      idx = (int'(arb_ptr) + o) % NUM_M;
      if (!win_found && m_req[idx]) begin
        win_found = 1'b1;
        win       = AW'(idx);
      end
    end

    // first bank with room, starting at the rotating write pointer
    for (int o = 0; o < 4; o++) begin
      if (!wb_found && cnt[wr_ptr + 2'(o)] < FULL_CNT) begin
        wb_found = 1'b1;
        wb       = wr_ptr + 2'(o);
      end
    end

    case (state)
      S_RUN: begin
        if (flush) begin
          state_nxt = S_FLUSH;
        end else if (win_found) begin
          ack_c[win]  = 1'b1;
          arb_ptr_nxt = AW'((int'(win) + 1) % NUM_M);
          if (m_we[win]) begin
            if (wb_found) begin
              wr_c[wb]    = 1'b1;
              wdata_c     = m_wdata[DATA_W*win +: DATA_W];
              cnt_nxt[wb] = cnt[wb] + CNT_W'(1);
              wr_ptr_nxt  = wb + 2'd1;
            end else begin
              err_c[win] = 1'b1;
            end
          end else begin
            rb = m_rd_id[2*win +: 2];
            if (cnt[rb] != '0) begin
              rd_c[rb]        = 1'b1;
              cnt_nxt[rb]     = cnt[rb] - CNT_W'(1);
              rvalid_nxt[win] = 1'b1;
              rd_bank_nxt     = rb;
            end else begin
              err_c[win] = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (cnt[0] == '0 && cnt[1] == '0 && cnt[2] == '0 && cnt[3] == '0) begin
          done_c    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (cnt[k] != '0) begin
              rd_c[k]    = 1'b1;
              cnt_nxt[k] = cnt[k] - CNT_W'(1);
            end
          end
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      arb_ptr    <= '0;
      wr_ptr     <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      rvalid_q   <= '0;
      rd_bank_q  <= '0;
      rdata_hold <= '0;
    end else begin
      state      <= state_nxt;
      arb_ptr    <= arb_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      cnt        <= cnt_nxt;
      rvalid_q   <= rvalid_nxt;
      rd_bank_q  <= rd_bank_nxt;
      rdata_hold <= m_rdata;
    end
  end

  // grant outputs are combinational, so gate them with reset to drop them immediately
  assign m_ack      = rst ? ack_c   : '0;
  assign m_err      = rst ? err_c   : '0;
  assign b_wr_en    = rst ? wr_c    : '0;
  assign b_rd_en    = rst ? rd_c    : '0;
  assign b_wdata    = rst ? wdata_c : '0;
  assign flush_done = rst & done_c;
  assign m_rvalid   = rvalid_q;
  assign m_rdata    = (|rvalid_q) ? b_rdata[DATA_W*rd_bank_q +: DATA_W] : rdata_hold;

  always_comb begin
    bank_cnt = '0;
    for (int k = 0; k < 4; k++) bank_cnt[CNT_W*k +: CNT_W] = cnt[k];
  end

endmodule

// File: tb/tb_fifo_bank_scheduler.sv
// tb/tb_fifo_bank_scheduler.sv - directed self-checking bench for fifo_bank_scheduler
// Four behavioural FIFO banks with registered outputs stand in for the real bank pool.
module tb_fifo_bank_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  m_req, m_we, m_ack, m_err, m_rvalid;
  logic [3:0]  m_rd_id;
  logic [15:0] m_wdata;
  logic [7:0]  m_rdata, b_wdata;
  logic        flush, flush_done;
  logic [3:0]  b_wr_en, b_rd_en;
  logic [31:0] b_rdata;
  logic [19:0] bank_cnt;

  int n_asrt = 0;
  int n_fail = 0;

  fifo_bank_scheduler #(.NUM_M(2), .DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_rd_id(m_rd_id),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .flush(flush), .flush_done(flush_done), .b_wr_en(b_wr_en),
    .b_rd_en(b_rd_en), .b_wdata(b_wdata), .b_rdata(b_rdata), .bank_cnt(bank_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  logic [7:0] mem [4][16];
  logic [3:0] wp [4];
  logic [3:0] rp [4];
  logic [7:0] bq [4];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        bq[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (b_wr_en[k]) begin
          mem[k][wp[k]] <= b_wdata;
          wp[k] <= wp[k] + 4'd1;
        end
        if (b_rd_en[k]) begin
          bq[k] <= mem[k][rp[k]];
          rp[k] <= rp[k] + 4'd1;
        end
      end
    end
  end

  assign b_rdata = {bq[3], bq[2], bq[1], bq[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_req = '0;
    flush = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {12'd0, 5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  logic [7:0] d1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [1:0] exp_ack2 [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [7:0] exp_wd2 [4] = '{8'hA1, 8'hB0, 8'hA1, 8'hB0};
  logic [3:0] exp_fl [5] = '{4'b1101, 4'b0101, 4'b0101, 4'b0100, 4'b0100};
  logic [1:0] rd_list [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b0;
    m_req = 2'b01;
    m_we = 2'b01;
    m_rd_id = '0;
    m_wdata = '0;
    flush = 1'b0;
    #3;
    chk("rst_ack", 32'(m_ack), 32'h0);
    chk("rst_wr_en", 32'(b_wr_en), 32'h0);
    chk("rst_rd_en", 32'(b_rd_en), 32'h0);
    chk("rst_cnt", 32'(bank_cnt), 32'h0);
    chk("rst_rdata", 32'(m_rdata), 32'h0);
    chk("rst_done", 32'(flush_done), 32'h0);
    m_req = '0;
    tick();
    rst = 1'b1;

    // single master writes rotate through the banks
    for (int i = 0; i < 4; i++) begin
      m_req = 2'b01; m_we = 2'b01; m_wdata = {8'h00, d1[i]};
      #3;
      chk("t1_ack", 32'(m_ack), 32'h1);
      chk("t1_wr_en", 32'(b_wr_en), 32'(4'b0001 << i));
      chk("t1_wdata", 32'(b_wdata), 32'(d1[i]));
      tick();
    end
    m_req = '0;
    #3;
    chk("t1_cnt", 32'(bank_cnt), pk(1, 1, 1, 1));
    chk("t1_idle_wdata", 32'(b_wdata), 32'h0);
    tick();

    // both masters requesting: grants alternate, starting from M1 since M0 won last
    m_req = 2'b11; m_we = 2'b11; m_wdata = {8'hA1, 8'hB0};
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("t2_ack", 32'(m_ack), 32'(exp_ack2[i]));
      chk("t2_wdata", 32'(b_wdata), 32'(exp_wd2[i]));
      chk("t2_wr_en", 32'(b_wr_en), 32'(4'b0001 << i));
      tick();
    end
    m_req = '0;
    #3;
    chk("t2_cnt", 32'(bank_cnt), pk(2, 2, 2, 2));
    tick();
    m_req = 2'b01; m_we = 2'b00; m_rd_id = 4'b0001;
    #3;
    chk("t2_rd_ack", 32'(m_ack), 32'h1);
    chk("t2_rd_en", 32'(b_rd_en), 32'b0010);
    tick();
    m_req = '0;
    #3;
    chk("t2_rvalid", 32'(m_rvalid), 32'h1);
    chk("t2_rdata", 32'(m_rdata), 32'h22);
    tick();

    // read of an empty bank
    do_reset();
    m_req = 2'b10; m_we = 2'b00; m_rd_id = 4'b1000;
    #3;
    chk("t4_empty_ack", 32'(m_ack), 32'h2);
    chk("t4_empty_err", 32'(m_err), 32'h2);
    chk("t4_empty_rd_en", 32'(b_rd_en), 32'h0);
    tick();
    m_req = '0;
    #3;
    chk("t4_empty_rvalid", 32'(m_rvalid), 32'h0);
    tick();

    // fill all four banks
    for (int i = 0; i < 64; i++) begin
      m_req = 2'b01; m_we = 2'b01; m_wdata = {8'h00, 8'(i)};
      #3;
      chk("t3_fill_wr_en", 32'(b_wr_en), 32'(4'b0001 << (i % 4)));
      tick();
    end
    m_req = '0;
    #3;
    chk("t3_full_cnt", 32'(bank_cnt), pk(16, 16, 16, 16));
    tick();
    m_req = 2'b01; m_we = 2'b01;
    #3;
    chk("t4_full_ack", 32'(m_ack), 32'h1);
    chk("t4_full_err", 32'(m_err), 32'h1);
    chk("t4_full_wr_en", 32'(b_wr_en), 32'h0);
    tick();
    m_req = '0;
    #3;
    chk("t4_full_cnt", 32'(bank_cnt), pk(16, 16, 16, 16));
    tick();

    // drain bank0 back-to-back; data comes back in write order
    m_req = 2'b10; m_we = 2'b00; m_rd_id = 4'b0000;
    for (int j = 0; j < 16; j++) begin
      #3;
      chk("t3_rd_ack", 32'(m_ack), 32'h2);
      chk("t3_rd_en", 32'(b_rd_en), 32'b0001);
      if (j > 0) begin
        chk("t3_rvalid", 32'(m_rvalid), 32'h2);
        chk("t3_rdata", 32'(m_rdata), 32'(4 * (j - 1)));
      end
      if (j == 1) chk("t3_cnt15", 32'(bank_cnt[4:0]), 32'd15);
      tick();
    end
    m_req = '0;
    #3;
    chk("t3_last_rvalid", 32'(m_rvalid), 32'h2);
    chk("t3_last_rdata", 32'(m_rdata), 32'd60);
    tick();
    #3;
    chk("t3_rvalid_low", 32'(m_rvalid), 32'h0);
    chk("t3_rdata_hold", 32'(m_rdata), 32'd60);
    tick();
    m_req = 2'b10;
    #3;
    chk("t4_drained_err", 32'(m_err), 32'h2);
    chk("t4_drained_rd_en", 32'(b_rd_en), 32'h0);
    tick();
    m_req = '0;
    #3;
    chk("t4_drained_rvalid", 32'(m_rvalid), 32'h0);
    tick();

    // build counts {3,0,5,1}, then flush with a write request held
    do_reset();
    for (int i = 0; i < 20; i++) begin
      m_req = 2'b01; m_we = 2'b01; m_wdata = {8'h00, 8'(i)};
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      m_req = 2'b01; m_we = 2'b00; m_rd_id = {2'b00, rd_list[i]};
      tick();
    end
    m_req = '0;
    #3;
    chk("t5_pre_cnt", 32'(bank_cnt), pk(3, 0, 5, 1));
    tick();
    m_req = 2'b01; m_we = 2'b01; m_wdata = {8'h00, 8'h77}; flush = 1'b1;
    #3;
    chk("t5_flush_ack", 32'(m_ack), 32'h0);
    chk("t5_flush_wr_en", 32'(b_wr_en), 32'h0);
    tick();
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("t5_drain_rd_en", 32'(b_rd_en), 32'(exp_fl[c]));
      chk("t5_drain_ack", 32'(m_ack), 32'h0);
      chk("t5_drain_done", 32'(flush_done), 32'h0);
      tick();
    end
    #3;
    chk("t5_done", 32'(flush_done), 32'h1);
    chk("t5_done_rd_en", 32'(b_rd_en), 32'h0);
    chk("t5_done_ack", 32'(m_ack), 32'h0);
    chk("t5_done_cnt", 32'(bank_cnt), 32'h0);
    tick();
    #3;
    chk("t5_post_ack", 32'(m_ack), 32'h1);
    chk("t5_post_wr_en", 32'(b_wr_en), 32'b0001);
    chk("t5_post_wdata", 32'(b_wdata), 32'h77);
    chk("t5_post_done", 32'(flush_done), 32'h0);
    tick();

    // reset in the middle of a write burst
    tick();
    #2;
    rst = 1'b0;
    #2;
    chk("t6_wr_rst_ack", 32'(m_ack), 32'h0);
    chk("t6_wr_rst_wr_en", 32'(b_wr_en), 32'h0);
    chk("t6_wr_rst_cnt", 32'(bank_cnt), 32'h0);
    chk("t6_wr_rst_rdata", 32'(m_rdata), 32'h0);
    tick();
    rst = 1'b1;
    #3;
    chk("t6_first_wr_en", 32'(b_wr_en), 32'b0001);
    chk("t6_first_ack", 32'(m_ack), 32'h1);
    tick();

    // reset while a read is being granted drops the read
    m_req = 2'b01; m_we = 2'b00; m_rd_id = 4'b0000;
    #3;
    chk("t6_rd_ack", 32'(m_ack), 32'h1);
    chk("t6_rd_en", 32'(b_rd_en), 32'b0001);
    #2;
    rst = 1'b0;
    m_req = '0;
    #2;
    chk("t6_rd_rst_ack", 32'(m_ack), 32'h0);
    chk("t6_rd_rst_rd_en", 32'(b_rd_en), 32'h0);
    tick();
    chk("t6_rd_rst_rvalid", 32'(m_rvalid), 32'h0);
    rst = 1'b1;
    #3;
    chk("t6_rd_post_rvalid", 32'(m_rvalid), 32'h0);
    chk("t6_rd_post_cnt", 32'(bank_cnt), 32'h0);
    m_req = 2'b01; m_we = 2'b01;
    #1;
    chk("t6_rd_post_wr_en", 32'(b_wr_en), 32'b0001);
    tick();
    m_req = '0;

    // flush with every bank already empty
    do_reset();
    flush = 1'b1;
    #3;
    chk("t5_empty_flush_done0", 32'(flush_done), 32'h0);
    tick();
    flush = 1'b0;
    #3;
    chk("t5_empty_flush_done", 32'(flush_done), 32'h1);
    chk("t5_empty_flush_rd_en", 32'(b_rd_en), 32'h0);
    tick();
    #3;
    chk("t5_empty_flush_after", 32'(flush_done), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
